// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg
//   Shared definitions for the loadable down-counting timer: FSM state
//   encoding and default width constants used by countdown_timer and
//   countdown_prescaler.
package countdown_timer_pkg;

  localparam int CDT_WIDTH      = 4;
  localparam int CDT_PRESCALE_W = 4;

  typedef enum logic {
    CDT_IDLE = 1'b0,
    CDT_RUN  = 1'b1
  } cdt_state_t;

endpackage : countdown_timer_pkg

// File: rtl/countdown_prescaler.sv
// countdown_prescaler
//   Tick divider for countdown_timer. Holds the divisor captured on load and
//   a counter that walks 0..divisor on enabled cycles while the timer runs,
//   wrapping back to 0. A tick is issued on the enabled cycle in which the
//   counter sits at the divisor, giving one tick per (divisor+1) enabled
//   cycles.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous reset, active-low
//   load      in   load transfer: capture load_div, clear the counter
//   load_div  in   divisor to capture on load
//   run       in   timer is in RUN
//   en        in   count enable; low freezes the counter
//   tick      out  decrement strobe for the timer (combinational)
module countdown_prescaler
  import countdown_timer_pkg::*;
#(
  parameter int PRESCALE_W = CDT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] load_div,
  input  logic                  run,
  input  logic                  en,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  at_terminal;

  assign at_terminal = (cnt_q == div_q);
  assign tick        = run && en && at_terminal;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      div_d = load_div;
      cnt_d = '0;
    end else if (run && en) begin
      cnt_d = at_terminal ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule : countdown_prescaler

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counting timer. A start value is taken over a valid/ready
//   handshake; the count then decrements on each tick and raises a one-cycle
//   expired pulse at terminal count, either stopping (one-shot) or reloading
//   the start value (periodic). abort stops the timer from any state.
//
//   Build option: define COUNTDOWN_TIMER_PRESCALER_EN to insert a prescaler
//   so that one tick occurs per (prescale_div+1) enabled cycles. Without it
//   every enabled cycle in RUN is a tick and prescale_div is ignored.
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous reset, active-low
//   en            in   count enable; low freezes count and prescaler
//   abort         in   synchronous stop back to IDLE, highest priority
//   load_valid    in   start value offered
//   load_ready    out  start value can be accepted (combinational)
//   load_data     in   start / reload value
//   periodic      in   mode captured on load: 1 reload, 0 one-shot
//   prescale_div  in   tick divisor captured on load (prescaler build only)
//   count         out  current count, registered
//   busy          out  high while in RUN
//   expired       out  one-cycle terminal-count pulse, registered
//
// State | meaning
// ------+----------------------------------------------------------
// IDLE  | stopped, count parked (0 after reset/abort/one-shot end)
// RUN   | counting down on ticks toward terminal count
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH      = CDT_WIDTH,
  parameter int PRESCALE_W = CDT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  abort,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_data,
  input  logic                  periodic,
  input  logic [PRESCALE_W-1:0] prescale_div,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  expired
);

  cdt_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             expired_q, expired_d;

  logic             load_fire;
  logic             running;
  logic             tick;

  assign running    = (state_q == CDT_RUN);
  assign load_ready = (state_q == CDT_IDLE) && !abort;
  assign load_fire  = load_valid && load_ready;

`ifdef COUNTDOWN_TIMER_PRESCALER_EN
  countdown_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_fire),
    .load_div (prescale_div),
    .run      (running),
    .en       (en),
    .tick     (tick)
  );
`else
  logic unused_prescale_div;
  assign unused_prescale_div = ^prescale_div;
  assign tick = running && en;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    mode_d    = mode_q;
    expired_d = 1'b0;

    if (abort) begin
      // Wins over a terminal count in the same cycle: no expired pulse.
      state_d = CDT_IDLE;
      count_d = '0;
      mode_d  = 1'b0;
    end else begin
      case (state_q)
        CDT_IDLE: begin
          if (load_fire) begin
            count_d  = load_data;
            reload_d = load_data;
            mode_d   = periodic;
            // A zero start value is already at terminal count.
            if (load_data == '0) begin
              expired_d = 1'b1;
            end else begin
              state_d = CDT_RUN;
            end
          end
        end
        CDT_RUN: begin
          if (tick) begin
            if (count_q == WIDTH'(1)) begin
              expired_d = 1'b1;
              if (mode_q) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = CDT_IDLE;
              end
            end else if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = CDT_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CDT_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      mode_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      expired_q <= expired_d;
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == CDT_RUN);
  assign expired = expired_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Self-checking bench for countdown_timer. Each stimulus cycle pushes the
//   expected post-edge outputs to a scoreboard queue; after the edge the
//   entry is popped and compared with the DUT outputs.
module tb_countdown_timer;

  localparam int W  = 4;
  localparam int PW = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          abort;
  logic          load_valid;
  logic          load_ready;
  logic [W-1:0]  load_data;
  logic          periodic;
  logic [PW-1:0] prescale_div;
  logic [W-1:0]  count;
  logic          busy;
  logic          expired;

  countdown_timer #(
    .WIDTH      (W),
    .PRESCALE_W (PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .abort        (abort),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .periodic     (periodic),
    .prescale_div (prescale_div),
    .count        (count),
    .busy         (busy),
    .expired      (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         expired;
  } exp_t;

  exp_t  sb_q[$];
  string sb_tag_q[$];

  int n_vectors     = 0;
  int n_miscompares = 0;

  task automatic chk_val(input string tag, input int got, input int want);
    n_vectors++;
    if (got !== want) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Push the expected post-edge outputs, advance one edge, then pop and
  // compare against the DUT.
  task automatic step(input string tag, input int c, input bit b, input bit e);
    exp_t  x;
    string t;
    x.count   = W'(c);
    x.busy    = b;
    x.expired = e;
    sb_q.push_back(x);
    sb_tag_q.push_back(tag);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    t = sb_tag_q.pop_front();
    chk_val({t, ".count"},   int'(count),   int'(x.count));
    chk_val({t, ".busy"},    int'(busy),    int'(x.busy));
    chk_val({t, ".expired"}, int'(expired), int'(x.expired));
  endtask

  task automatic offer(input int d, input bit per, input int div);
    load_valid   = 1'b1;
    load_data    = W'(d);
    periodic     = per;
    prescale_div = PW'(div);
  endtask

  initial begin
    rst_n        = 1'b0;
    en           = 1'b0;
    abort        = 1'b0;
    load_valid   = 1'b0;
    load_data    = '0;
    periodic     = 1'b0;
    prescale_div = '0;

    // Reset values; load_ready is combinational and high during reset.
    #12;
    chk_val("rst.count",      int'(count),      0);
    chk_val("rst.busy",       int'(busy),       0);
    chk_val("rst.expired",    int'(expired),    0);
    chk_val("rst.load_ready", int'(load_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One-shot 5, then back-to-back restart with 1 in the pulse cycle.
    en = 1'b1;
    offer(5, 1'b0, 0);
    step("os5.load", 5, 1, 0);
    load_valid = 1'b0;
    chk_val("os5.ready_run", int'(load_ready), 0);
    step("os5.c4", 4, 1, 0);
    step("os5.c3", 3, 1, 0);
    step("os5.c2", 2, 1, 0);
    step("os5.c1", 1, 1, 0);
    step("os5.c0", 0, 0, 1);
    chk_val("os5.ready_pulse", int'(load_ready), 1);
    offer(1, 1'b0, 0);
    step("b2b.load", 1, 1, 0);
    load_valid = 1'b0;
    step("b2b.c0", 0, 0, 1);
    step("b2b.idle", 0, 0, 0);

    // Periodic 3 for 10 cycles after the load edge, then abort.
    offer(3, 1'b1, 0);
    step("per3.load", 3, 1, 0);
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("per3.c2", 2, 1, 0);
      step("per3.c1", 1, 1, 0);
      step("per3.rl", 3, 1, 1);
      chk_val("per3.ready", int'(load_ready), 0);
    end
    abort = 1'b1;
    chk_val("per3.ready_abort", int'(load_ready), 0);
    step("per3.abort", 0, 0, 0);
    abort = 1'b0;
    step("per3.idle", 0, 0, 0);

    // One-shot 4 with en dropped for 3 cycles after the first decrement.
    offer(4, 1'b0, 0);
    step("hold.load", 4, 1, 0);
    load_valid = 1'b0;
    step("hold.c3", 3, 1, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) step("hold.frz", 3, 1, 0);
    en = 1'b1;
    step("hold.c2", 2, 1, 0);
    step("hold.c1", 1, 1, 0);
    step("hold.c0", 0, 0, 1);
    step("hold.idle", 0, 0, 0);

    // Load of 0: immediate expired pulse, never busy.
    offer(0, 1'b0, 0);
    step("zero.pulse", 0, 0, 1);
    load_valid = 1'b0;
    step("zero.after", 0, 0, 0);

    // Periodic 6, abort together with a new load at count 2.
    offer(6, 1'b1, 0);
    step("ab.load", 6, 1, 0);
    load_valid = 1'b0;
    step("ab.c5", 5, 1, 0);
    step("ab.c4", 4, 1, 0);
    step("ab.c3", 3, 1, 0);
    step("ab.c2", 2, 1, 0);
    abort = 1'b1;
    offer(9, 1'b1, 0);
    chk_val("ab.ready", int'(load_ready), 0);
    step("ab.stop", 0, 0, 0);
    abort      = 1'b0;
    load_valid = 1'b0;
    step("ab.idle", 0, 0, 0);

    // Abort exactly at a pending one-shot terminal count suppresses expired.
    offer(2, 1'b0, 0);
    step("abt.load", 2, 1, 0);
    load_valid = 1'b0;
    step("abt.c1", 1, 1, 0);
    abort = 1'b1;
    step("abt.stop", 0, 0, 0);
    abort = 1'b0;
    step("abt.idle", 0, 0, 0);

`ifdef COUNTDOWN_TIMER_PRESCALER_EN
    // Divisor 2: one decrement every 3 enabled cycles.
    offer(2, 1'b0, 2);
    step("pre.load", 2, 1, 0);
    load_valid = 1'b0;
    step("pre.p0", 2, 1, 0);
    step("pre.p1", 2, 1, 0);
    step("pre.c1", 1, 1, 0);
    step("pre.p3", 1, 1, 0);
    step("pre.p4", 1, 1, 0);
    step("pre.c0", 0, 0, 1);
    step("pre.idle", 0, 0, 0);
    offer(5, 1'b0, 2);
    step("prst.load", 5, 1, 0);
    load_valid = 1'b0;
    step("prst.p0", 5, 1, 0);
    step("prst.p1", 5, 1, 0);
    step("prst.c4", 4, 1, 0);
`else
    // Without the prescaler, prescale_div is ignored.
    offer(5, 1'b0, 2);
    step("prst.load", 5, 1, 0);
    load_valid = 1'b0;
    step("prst.c4", 4, 1, 0);
    step("prst.c3", 3, 1, 0);
`endif

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("arst.count",   int'(count),   0);
    chk_val("arst.busy",    int'(busy),    0);
    chk_val("arst.expired", int'(expired), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("arst.idle", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting timer: the decrementing counterpart to the team's 4-bit loadable up-counter. A start value is accepted over a valid/ready load handshake. The block counts down to zero on enabled ticks and emits a one-cycle `expired` pulse at terminal count, either stopping (one-shot) or reloading (periodic). It sits beside the up-counter in the Tiny Tapeout user design as the timeout/interval generator.

## Interface
- `WIDTH`, 4: counter and load-data width.
- `PRESCALE_W`, 4: prescaler divisor width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `en`  in  1  count enable; low freezes count and prescaler.
- `abort`  in  1  synchronous stop; returns to IDLE.
- `load_valid`  in  1  start value offered.
- `load_ready`  out  1  block can accept a start value.
- `load_data`  in  WIDTH  start/reload value.
- `periodic`  in  1  mode, sampled on load: 1 = reload at terminal count, 0 = one-shot.
- `prescale_div`  in  PRESCALE_W  tick divisor, sampled on load; used only when the prescaler is compiled in.
- `count`  out  WIDTH  current count, registered.
- `busy`  out  1  high in RUN.
- `expired`  out  1  one-cycle terminal-count pulse, registered.

## Operation
- Reset values: `count`=0, `busy`=0, `expired`=0, state IDLE.
- Internal registers are cleared by reset: reload value, mode bit, prescale divisor, prescaler count.
- FSM has two states: IDLE and RUN.
- `load_ready` = (state==IDLE) && !abort. It is combinational, and is high during reset when `abort` is low.
- Transfer occurs when `load_valid && load_ready`. On a transfer:
  - `count` <= `load_data`.
  - Reload value <= `load_data`.
  - Mode <= `periodic`.
  - Divisor <= `prescale_div`.
  - Prescaler count <= 0.
  - Next state is RUN.
- Load of 0: `expired` pulses in the next cycle; state stays IDLE; `count`=0.
- Tick: `en` && (prescaler at terminal), evaluated only in RUN.
- On each tick in RUN, `count` decrements. When `count`==1 on a tick:
  - One-shot: `count` <= 0, `expired` <= 1, next state IDLE.
  - Periodic: `count` <= reload value, `expired` <= 1, state stays RUN.
- `count` never underflows; there is no decrement in IDLE.
- `en` low in RUN: `count` and prescaler hold; `busy` stays 1.
- `abort`: top priority, in any state.
  - `count` <= 0, next state IDLE, `expired` stays 0 (a pending terminal count is suppressed).
  - Mode bit is cleared.
  - A simultaneous load is not accepted.
- Priority order: reset > abort > load > tick.
- Reloading while running requires `abort` first.

## Timing
- Load accepted at edge N: `count`=D after edge N. With `en` held high and the prescaler absent or divisor 0, the first decrement happens at edge N+1.
- One-shot: after edge N+D, `count`=0 and `expired`=1 for one cycle. `load_ready` is high in that same cycle, so back-to-back restart is possible.
- Periodic: `expired` pulses every D ticks; `count` reads D in the pulse cycle.
- Prescaled: one tick per (divisor+1) enabled cycles.
- Load of 0: `expired` is high in cycle N+1.
- `abort` asserted before edge M: `busy`=0 and `count`=0 after edge M.
- Reset mid-run: outputs return to reset values immediately (asynchronous); there is no `expired` pulse.

## Configuration
- Macro: `COUNTDOWN_TIMER_PRESCALER_EN`.
- Defined:
  - The prescaler counts 0..divisor on enabled cycles in RUN and wraps to 0.
  - A tick is asserted when prescaler==divisor and `en`=1.
- Undefined:
  - Tick = `en`.
  - The `prescale_div` port remains but is ignored; no prescaler registers are synthesised.

## Structure
- Shared package `countdown_timer_pkg`:
  - State enum `cdt_state_t` {CDT_IDLE, CDT_RUN}.
  - Default width constants `CDT_WIDTH`=4 and `CDT_PRESCALE_W`=4.
- Sub-module `countdown_prescaler`:
  - Contains the divisor register, the prescaler counter and the tick output.
  - Instantiated only under `COUNTDOWN_TIMER_PRESCALER_EN`.
- The top holds the FSM, count/reload registers and the handshake.

## Test plan
- Reset, then one-shot load 5 with `en`=1 -> `count` reads 5,4,3,2,1,0; `expired` is high exactly in the cycle `count`=0 (5 cycles after the load edge); `busy` then falls.
- Periodic load 3, `en`=1, for 10 cycles -> `count` sequence 3,2,1,3,2,1,3,...; `expired` pulses every 3 cycles; `load_ready` stays 0.
- One-shot load 4; drop `en` for 3 cycles after the first decrement -> `count` holds at 3; total time to `expired` grows by 3 cycles.
- Load 0 -> `expired` high for one cycle at N+1; `busy` never rises.
- Periodic load 6; assert `abort` together with `load_valid` at count 2 -> next cycle `count`=0, `busy`=0, no `expired`, load not accepted.
- With `COUNTDOWN_TIMER_PRESCALER_EN`, `prescale_div`=2, load 2 -> decrements every 3 cycles; `expired` 6 cycles after load; an async `rst_n` pulse mid-run clears all outputs immediately.
